// File: rtl/layer_reader.sv
// Purpose : fetch rows of input layers over AXI4 read bursts, one burst per row, and stream the bytes out.
// Latency : first byte appears the cycle after its beat is accepted; 1 byte/cycle with continuous rvalid and layer_rdy_i.
// Backpr. : layer_rdy_i low holds the output byte; rready drops while the beat holding register is occupied.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   Start                        one-cycle start pulse (ignored unless idle)
//   axi_address .. read_burst_len  transfer configuration, latched on Start
//   layer_data_o/layer_valid_o/layer_rdy_i  byte stream output
//   busy_o, done_o, rresp_err_o  status
//   M_axi_ar* / M_axi_r*         AXI4 read address / read data channels
module layer_reader #(
  parameter int C_S_AXI_ID_WIDTH   = 3,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          Start,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] axi_address,
  input  logic [9:0]                    no_of_input_layers,
  input  logic [9:0]                    input_layer_row_size,
  input  logic [9:0]                    input_layer_col_size,
  input  logic [15:0]                   allocated_space_per_row,
  input  logic [7:0]                    read_burst_len,
  output logic [7:0]                    layer_data_o,
  output logic                          layer_valid_o,
  input  logic                          layer_rdy_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          rresp_err_o,
  output logic [C_S_AXI_ID_WIDTH-1:0]   M_axi_arid,
  output logic [C_S_AXI_ADDR_WIDTH-1:0] M_axi_araddr,
  output logic [7:0]                    M_axi_arlen,
  output logic [2:0]                    M_axi_arsize,
  output logic [1:0]                    M_axi_arburst,
  output logic                          M_axi_arlock,
  output logic [3:0]                    M_axi_arcache,
  output logic [2:0]                    M_axi_arprot,
  output logic [3:0]                    M_axi_arqos,
  output logic                          M_axi_arvalid,
  input  logic                          M_axi_arready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   M_axi_rid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] M_axi_rdata,
  input  logic [1:0]                    M_axi_rresp,
  input  logic                          M_axi_rlast,
  input  logic                          M_axi_rvalid,
  output logic                          M_axi_rready
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, NEXT, DONE} state_t;

  state_t                        state;
  logic [9:0]                    layers_q, cols_q, row_size_q;
  logic [15:0]                   stride_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                    arlen_q;
  logic [9:0]                    row_q, layer_q;
  logic [11:0]                   row_cnt;   // bytes of the current row already claimed for output
  logic [63:0]                   hold_dat;  // remaining bytes of the accepted beat, next byte in [7:0]
  logic [3:0]                    hold_cnt;  // bytes still to emit from hold_dat
  logic                          got_last;  // rlast beat accepted, row ends once it drains
  logic [7:0]                    out_dat;
  logic                          out_vld;
  logic                          arvalid_q, busy_q, done_q, err_q;

  logic        beat_acc, out_free;
  logic [11:0] rem;
  logic [3:0]  keep;

  // The single burst carries only the fields below; rid is not needed with one outstanding read.
  logic unused_ok;
  assign unused_ok = &{1'b0, M_axi_rid};

  assign M_axi_arid    = '0;
  assign M_axi_arsize  = 3'b011;
  assign M_axi_arburst = 2'b01;
  assign M_axi_arlock  = 1'b0;
  assign M_axi_arcache = 4'b0011;
  assign M_axi_arprot  = 3'b000;
  assign M_axi_arqos   = 4'b0000;
  assign M_axi_araddr  = addr_q;
  assign M_axi_arlen   = arlen_q;
  assign M_axi_arvalid = arvalid_q;
  assign M_axi_rready  = (state == DATA) && (hold_cnt == 4'd0) && !got_last;

  assign layer_data_o  = out_dat;
  assign layer_valid_o = out_vld;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign rresp_err_o   = err_q;

  assign beat_acc = M_axi_rvalid && M_axi_rready;
  assign out_free = !out_vld || layer_rdy_i;

  // Bytes of an incoming beat that still fall inside the row; everything past the
  // row size is dropped with the beat, so discards never take output cycles.
  always_comb begin
    rem  = 12'd0;
    keep = 4'd0;
    if (row_cnt < {2'b00, row_size_q}) begin
      rem  = {2'b00, row_size_q} - row_cnt;
      keep = (rem >= 12'd8) ? 4'd8 : rem[3:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      layers_q   <= '0;
      cols_q     <= '0;
      row_size_q <= '0;
      stride_q   <= '0;
      addr_q     <= '0;
      arlen_q    <= '0;
      row_q      <= '0;
      layer_q    <= '0;
      row_cnt    <= '0;
      hold_dat   <= '0;
      hold_cnt   <= '0;
      got_last   <= 1'b0;
      out_dat    <= '0;
      out_vld    <= 1'b0;
      arvalid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            layers_q   <= no_of_input_layers;
            cols_q     <= input_layer_col_size;
            row_size_q <= input_layer_row_size;
            stride_q   <= allocated_space_per_row;
            addr_q     <= axi_address;
            arlen_q    <= read_burst_len;
            row_q      <= '0;
            layer_q    <= '0;
            row_cnt    <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            if (no_of_input_layers == 10'd0 || input_layer_col_size == 10'd0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state     <= ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end

        ADDR: begin
          if (M_axi_arready) begin
            arvalid_q <= 1'b0;
            row_cnt   <= '0;
            got_last  <= 1'b0;
            state     <= DATA;
          end
        end

        DATA: begin
          if (beat_acc) begin
            row_cnt  <= row_cnt + {8'd0, keep};
            got_last <= M_axi_rlast;
            if (M_axi_rresp != 2'b00) err_q <= 1'b1;
            if (out_free) begin
              // Byte 0 goes straight to the output so the stream never bubbles between beats.
              if (keep != 4'd0) begin
                out_dat  <= M_axi_rdata[7:0];
                out_vld  <= 1'b1;
                hold_dat <= {8'd0, M_axi_rdata[63:8]};
                hold_cnt <= keep - 4'd1;
              end else begin
                out_vld  <= 1'b0;
                hold_cnt <= 4'd0;
              end
            end else begin
              hold_dat <= M_axi_rdata[63:0];
              hold_cnt <= keep;
            end
          end else if (out_free) begin
            if (hold_cnt != 4'd0) begin
              out_dat  <= hold_dat[7:0];
              out_vld  <= 1'b1;
              hold_dat <= {8'd0, hold_dat[63:8]};
              hold_cnt <= hold_cnt - 4'd1;
            end else begin
              out_vld <= 1'b0;
              if (got_last) begin
                got_last <= 1'b0;
                state    <= NEXT;
              end
            end
          end
        end

        NEXT: begin
          addr_q <= addr_q + {{(C_S_AXI_ADDR_WIDTH-16){1'b0}}, stride_q};
          if (row_q == cols_q - 10'd1) begin
            row_q <= '0;
            if (layer_q == layers_q - 10'd1) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              layer_q   <= layer_q + 10'd1;
              state     <= ADDR;
              arvalid_q <= 1'b1;
            end
          end else begin
            row_q     <= row_q + 10'd1;
            state     <= ADDR;
            arvalid_q <= 1'b1;
          end
        end

        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_reader.sv
module tb_layer_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Start;
  logic [31:0] axi_address;
  logic [9:0]  no_of_input_layers, input_layer_row_size, input_layer_col_size;
  logic [15:0] allocated_space_per_row;
  logic [7:0]  read_burst_len;
  logic [7:0]  layer_data_o;
  logic        layer_valid_o, layer_rdy_i, busy_o, done_o, rresp_err_o;
  logic [2:0]  M_axi_arid;
  logic [31:0] M_axi_araddr;
  logic [7:0]  M_axi_arlen;
  logic [2:0]  M_axi_arsize;
  logic [1:0]  M_axi_arburst;
  logic        M_axi_arlock;
  logic [3:0]  M_axi_arcache;
  logic [2:0]  M_axi_arprot;
  logic [3:0]  M_axi_arqos;
  logic        M_axi_arvalid, M_axi_arready;
  logic [2:0]  M_axi_rid;
  logic [63:0] M_axi_rdata;
  logic [1:0]  M_axi_rresp;
  logic        M_axi_rlast, M_axi_rvalid, M_axi_rready;

  always #5 clk = ~clk;

  layer_reader dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .axi_address(axi_address),
    .no_of_input_layers(no_of_input_layers), .input_layer_row_size(input_layer_row_size),
    .input_layer_col_size(input_layer_col_size), .allocated_space_per_row(allocated_space_per_row),
    .read_burst_len(read_burst_len), .layer_data_o(layer_data_o), .layer_valid_o(layer_valid_o),
    .layer_rdy_i(layer_rdy_i), .busy_o(busy_o), .done_o(done_o), .rresp_err_o(rresp_err_o),
    .M_axi_arid(M_axi_arid), .M_axi_araddr(M_axi_araddr), .M_axi_arlen(M_axi_arlen),
    .M_axi_arsize(M_axi_arsize), .M_axi_arburst(M_axi_arburst), .M_axi_arlock(M_axi_arlock),
    .M_axi_arcache(M_axi_arcache), .M_axi_arprot(M_axi_arprot), .M_axi_arqos(M_axi_arqos),
    .M_axi_arvalid(M_axi_arvalid), .M_axi_arready(M_axi_arready), .M_axi_rid(M_axi_rid),
    .M_axi_rdata(M_axi_rdata), .M_axi_rresp(M_axi_rresp), .M_axi_rlast(M_axi_rlast),
    .M_axi_rvalid(M_axi_rvalid), .M_axi_rready(M_axi_rready)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Slave model and scoreboard state
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_ar[$];
  logic [31:0] pend_addr[$];
  int          pend_len[$];
  int          cur_beat = 0;
  bit          beat_pending = 0;
  int          beat_glob = 0;
  int          err_beat = -1;
  int          cfg_row_size = 0;
  logic [7:0]  cfg_arlen = 8'd0;
  bit          rnd = 0;
  int          ar_cnt = 0, byte_cnt = 0, done_cnt = 0, arvalid_seen = 0;
  int          cyc = 0, first_vld = -1, last_vld = -1;
  bit          prev_stall = 0, prev_ar_stall = 0;
  logic [7:0]  prev_dat;
  logic [31:0] prev_araddr;

  function automatic logic [7:0] pat(input logic [31:0] a, input int idx);
    logic [31:0] t;
    t = (a >> 6) * 32'd37 + 32'(idx);
    return t[7:0];
  endfunction

  // Bus process: drive slave/sink inputs just after the rising edge, observe at the falling edge.
  initial begin
    logic [63:0] d;
    logic [7:0]  e;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!reset_n) begin
        M_axi_rvalid = 1'b0;
      end else if (!beat_pending) begin
        if (pend_len.size() > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
          for (int i = 0; i < 8; i++) begin
            d[i*8 +: 8] = pat(pend_addr[0], cur_beat*8 + i);
            if (cur_beat*8 + i < cfg_row_size) exp_bytes.push_back(d[i*8 +: 8]);
          end
          M_axi_rdata  = d;
          M_axi_rlast  = (cur_beat == pend_len[0]);
          M_axi_rresp  = (beat_glob == err_beat) ? 2'b10 : 2'b00;
          M_axi_rvalid = 1'b1;
          beat_pending = 1;
          beat_glob++;
        end else begin
          M_axi_rvalid = 1'b0;
          M_axi_rdata  = {$urandom, $urandom};
        end
      end
      M_axi_arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      layer_rdy_i   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;

      @(negedge clk);
      if (reset_n) begin
        if (M_axi_arvalid) arvalid_seen++;
        if (prev_ar_stall) begin
          tests_run++;
          if (!M_axi_arvalid || M_axi_araddr !== prev_araddr) begin
            tests_failed++;
            $display("FAIL ar_stable: arvalid=%b araddr=%h required arvalid=1 araddr=%h",
                     M_axi_arvalid, M_axi_araddr, prev_araddr);
          end
        end
        prev_ar_stall = M_axi_arvalid && !M_axi_arready;
        prev_araddr   = M_axi_araddr;
        if (M_axi_arvalid && M_axi_arready) begin
          ar_cnt++;
          tests_run++;
          if (exp_ar.size() == 0) begin
            tests_failed++;
            $display("FAIL ar_addr: got %h, no AR expected", M_axi_araddr);
          end else begin
            if (M_axi_araddr !== exp_ar[0]) begin
              tests_failed++;
              $display("FAIL ar_addr: got %h required %h", M_axi_araddr, exp_ar[0]);
            end
            void'(exp_ar.pop_front());
          end
          tests_run++;
          if ({M_axi_arid, M_axi_arlen, M_axi_arsize, M_axi_arburst, M_axi_arlock,
               M_axi_arcache, M_axi_arprot, M_axi_arqos} !==
              {3'd0, cfg_arlen, 3'b011, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0}) begin
            tests_failed++;
            $display("FAIL ar_fields: arlen=%h arsize=%b arburst=%b arcache=%b required arlen=%h 011 01 0011",
                     M_axi_arlen, M_axi_arsize, M_axi_arburst, M_axi_arcache, cfg_arlen);
          end
          pend_addr.push_back(M_axi_araddr);
          pend_len.push_back(int'(M_axi_arlen));
        end
        if (M_axi_rvalid && M_axi_rready && pend_len.size() > 0) begin
          beat_pending = 0;
          cur_beat++;
          if (cur_beat > pend_len[0]) begin
            void'(pend_len.pop_front());
            void'(pend_addr.pop_front());
            cur_beat = 0;
          end
        end
        if (prev_stall) begin
          tests_run++;
          if (!layer_valid_o || layer_data_o !== prev_dat) begin
            tests_failed++;
            $display("FAIL out_stable: valid=%b data=%h required valid=1 data=%h",
                     layer_valid_o, layer_data_o, prev_dat);
          end
        end
        prev_stall = layer_valid_o && !layer_rdy_i;
        prev_dat   = layer_data_o;
        if (layer_valid_o) begin
          if (first_vld < 0) first_vld = cyc;
          last_vld = cyc;
        end
        if (layer_valid_o && layer_rdy_i) begin
          byte_cnt++;
          tests_run++;
          if (exp_bytes.size() == 0) begin
            tests_failed++;
            $display("FAIL byte: got %h, no byte expected", layer_data_o);
          end else begin
            e = exp_bytes.pop_front();
            if (layer_data_o !== e) begin
              tests_failed++;
              $display("FAIL byte: got %h required %h", layer_data_o, e);
            end
          end
        end
        if (done_o) done_cnt++;
      end
    end
  end

  task automatic clear_model();
    exp_bytes.delete();
    exp_ar.delete();
    pend_addr.delete();
    pend_len.delete();
    cur_beat      = 0;
    beat_pending  = 0;
    M_axi_rvalid  = 1'b0;
    prev_stall    = 0;
    prev_ar_stall = 0;
  endtask

  task automatic start_run(input logic [31:0] base, input int layers, input int rows,
                           input int rsize, input int stride, input int len, input bit random);
    @(posedge clk); #2;
    rnd          = random;
    cfg_row_size = rsize;
    cfg_arlen    = 8'(len);
    for (int k = 0; k < layers * rows; k++) exp_ar.push_back(base + 32'(k * stride));
    ar_cnt = 0; byte_cnt = 0; done_cnt = 0; arvalid_seen = 0;
    first_vld = -1; last_vld = -1;
    axi_address             = base;
    no_of_input_layers      = 10'(layers);
    input_layer_col_size    = 10'(rows);
    input_layer_row_size    = 10'(rsize);
    allocated_space_per_row = 16'(stride);
    read_burst_len          = 8'(len);
    Start = 1'b1;
    @(posedge clk); #2;
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #3;
      if (done_cnt > 0) begin
        ok = 1;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({M_axi_arvalid, M_axi_rready, layer_valid_o, busy_o, done_o, rresp_err_o} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {M_axi_arvalid, M_axi_rready, layer_valid_o, busy_o, done_o, rresp_err_o});
    end
    tests_run++;
    if (M_axi_araddr !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_araddr: got %h required 0", M_axi_araddr);
    end
    tests_run++;
    if ({M_axi_arlen, layer_data_o} !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_len_data: got %h required 0", {M_axi_arlen, layer_data_o});
    end
    @(negedge clk); #2;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    start_run(32'h1000, 2, 3, 5, 64, 0, 0);
    wait_done(2000, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL basic_done: timeout, got no done_o required 1 pulse"); end
    tests_run++;
    if (ar_cnt != 6) begin tests_failed++; $display("FAIL basic_ar_cnt: got %0d required 6", ar_cnt); end
    tests_run++;
    if (byte_cnt != 30) begin tests_failed++; $display("FAIL basic_bytes: got %0d required 30", byte_cnt); end
    tests_run++;
    if (done_cnt != 1) begin tests_failed++; $display("FAIL basic_done_pulse: got %0d cycles required 1", done_cnt); end
    tests_run++;
    if (exp_bytes.size() != 0 || exp_ar.size() != 0) begin
      tests_failed++;
      $display("FAIL basic_leftover: bytes=%0d ars=%0d required 0 0", exp_bytes.size(), exp_ar.size());
    end
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL basic_busy: got %b required 0", busy_o); end
  endtask

  task automatic test_throughput();
    bit ok;
    start_run(32'h2000, 1, 1, 64, 64, 7, 0);
    wait_done(2000, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL tput_done: timeout, required done_o"); end
    tests_run++;
    if (byte_cnt != 64) begin tests_failed++; $display("FAIL tput_bytes: got %0d required 64", byte_cnt); end
    tests_run++;
    if (last_vld - first_vld + 1 != 64) begin
      tests_failed++;
      $display("FAIL tput_span: got %0d cycles required 64", last_vld - first_vld + 1);
    end
  endtask

  task automatic test_random();
    bit ok;
    start_run(32'h3000, 2, 2, 55, 64, 6, 1);
    wait_done(20000, ok);
    rnd = 0;
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL rand_done: timeout, required done_o"); end
    tests_run++;
    if (byte_cnt != 220) begin tests_failed++; $display("FAIL rand_bytes: got %0d required 220", byte_cnt); end
    tests_run++;
    if (ar_cnt != 4) begin tests_failed++; $display("FAIL rand_ar_cnt: got %0d required 4", ar_cnt); end
    tests_run++;
    if (exp_bytes.size() != 0) begin tests_failed++; $display("FAIL rand_leftover: got %0d required 0", exp_bytes.size()); end
  endtask

  task automatic test_zero_layers();
    bit ok;
    start_run(32'h0, 0, 3, 5, 64, 0, 0);
    tests_run++;
    if ({done_o, busy_o} !== 2'b11) begin
      tests_failed++;
      $display("FAIL zero_done: got done/busy=%b required 11", {done_o, busy_o});
    end
    @(posedge clk); #2;
    tests_run++;
    if ({done_o, busy_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL zero_idle: got done/busy=%b required 00", {done_o, busy_o});
    end
    start_run(32'h0, 3, 0, 5, 64, 0, 0);
    wait_done(20, ok);
    tests_run++;
    if (!ok || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL zero_cols_done: got %0d done cycles required 1", done_cnt);
    end
    tests_run++;
    if (arvalid_seen != 0 || exp_ar.size() != 0) begin
      tests_failed++;
      $display("FAIL zero_arvalid: got %0d arvalid cycles required 0", arvalid_seen);
    end
    exp_ar.delete();
  endtask

  task automatic test_rresp_err();
    bit ok;
    err_beat = beat_glob + 1;
    start_run(32'h4000, 1, 1, 16, 64, 1, 0);
    wait_done(2000, ok);
    tests_run++;
    if (!ok || byte_cnt != 16) begin
      tests_failed++;
      $display("FAIL err_bytes: got %0d bytes required 16", byte_cnt);
    end
    repeat (5) @(posedge clk);
    #2;
    tests_run++;
    if (rresp_err_o !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b required 1", rresp_err_o); end
    err_beat = -1;
    start_run(32'h4400, 1, 1, 8, 64, 0, 0);
    tests_run++;
    if (rresp_err_o !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got %b required 0", rresp_err_o); end
    wait_done(2000, ok);
    tests_run++;
    if (!ok || byte_cnt != 8) begin tests_failed++; $display("FAIL err_rerun: got %0d bytes required 8", byte_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    start_run(32'h5000, 2, 2, 40, 64, 4, 0);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (layer_valid_o) begin
        seen = 1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL rstmid_valid: got no layer_valid_o required 1"); end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({M_axi_arvalid, M_axi_rready, layer_valid_o, busy_o, done_o, rresp_err_o} !== 6'b0 ||
        M_axi_araddr !== 32'd0 || {M_axi_arlen, layer_data_o} !== 16'd0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: ctrl=%b araddr=%h len/data=%h required all 0",
               {M_axi_arvalid, M_axi_rready, layer_valid_o, busy_o, done_o, rresp_err_o},
               M_axi_araddr, {M_axi_arlen, layer_data_o});
    end
    clear_model();
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
    start_run(32'h6000, 1, 2, 12, 128, 1, 0);
    wait_done(2000, ok);
    tests_run++;
    if (!ok || byte_cnt != 24 || ar_cnt != 2) begin
      tests_failed++;
      $display("FAIL rstmid_rerun: got bytes=%0d ars=%0d required 24 2", byte_cnt, ar_cnt);
    end
  endtask

  task automatic test_busy_start();
    bit ok;
    start_run(32'h7000, 1, 3, 10, 32, 1, 0);
    for (int k = 0; k < 3; k++) begin
      repeat (4) @(posedge clk);
      #2;
      axi_address        = 32'hDEAD0000;
      no_of_input_layers = 10'd5;
      Start = 1'b1;
      @(posedge clk); #2;
      Start = 1'b0;
    end
    wait_done(2000, ok);
    tests_run++;
    if (!ok || ar_cnt != 3 || byte_cnt != 30) begin
      tests_failed++;
      $display("FAIL busy_start: got ars=%0d bytes=%0d required 3 30", ar_cnt, byte_cnt);
    end
    repeat (5) @(posedge clk);
    #2;
    tests_run++;
    if (busy_o !== 1'b0 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL busy_start_idle: got busy=%b done=%0d required 0 1", busy_o, done_cnt);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    Start = 1'b0;
    axi_address = '0;
    no_of_input_layers = '0;
    input_layer_row_size = '0;
    input_layer_col_size = '0;
    allocated_space_per_row = '0;
    read_burst_len = '0;
    layer_rdy_i = 1'b0;
    M_axi_arready = 1'b0;
    M_axi_rid = '0;
    M_axi_rdata = '0;
    M_axi_rresp = 2'b00;
    M_axi_rlast = 1'b0;
    M_axi_rvalid = 1'b0;
    test_reset();
    test_basic();
    test_throughput();
    test_random();
    test_zero_layers();
    test_rresp_err();
    test_reset_mid();
    test_busy_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
